// File: rtl/receptor_hamming_serial_if.sv
// Serial receive link and corrected-word handshake for receptor_hamming_serial.
// The receptor takes the slave view. The link driver and the word consumer take the master view.
interface receptor_hamming_serial_if #(
   parameter int CNT_W = 8
);
   logic             rx_bit;
   logic             rx_valid;
   logic [10:0]      dado;
   logic             dado_valid;
   logic             dado_ready;
   logic [3:0]       sindrome;
   logic             erro_corrigido;
   logic             frame_err;
   logic             overrun;
   logic [CNT_W-1:0] err_count;

   modport master (
      output rx_bit, rx_valid, dado_ready,
      input  dado, dado_valid, sindrome, erro_corrigido, frame_err, overrun, err_count
   );

   modport slave (
      input  rx_bit, rx_valid, dado_ready,
      output dado, dado_valid, sindrome, erro_corrigido, frame_err, overrun, err_count
   );
endinterface

// File: rtl/receptor_hamming_serial.sv
// Serial Hamming(15,11) receiver. It frames a codeword, corrects single-bit errors and holds the word in a 1-entry output register.
// Defining HAMMING_STATS_EN builds the saturating err_count, cnt_frame_err and cnt_overrun counters.
module receptor_hamming_serial #(
   parameter int CNT_W     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   receptor_hamming_serial_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, STOP, CHECK} state_e;

   state_e      state_q;
   logic [14:0] shift_q;
   logic [3:0]  bit_cnt_q;
   logic [10:0] dado_q;
   logic        dado_valid_q;
   logic [3:0]  sindrome_q;
   logic        erro_q;
   logic        frame_err_q;
   logic        overrun_q;

   logic [3:0]  sindrome_d;
   logic [14:0] fixed_d;
   logic [10:0] dado_d;
   logic        load;
   logic        accept;

   always_comb begin
      // NOTE: every output of this block gets a value first, so no latch can be inferred.
      sindrome_d = 4'd0;
      for (int i = 1; i <= 15; i++) begin
         if (shift_q[i-1]) sindrome_d = sindrome_d ^ 4'(i);
      end
      fixed_d = shift_q;
      if (sindrome_d != 4'd0) fixed_d[sindrome_d - 4'd1] = ~shift_q[sindrome_d - 4'd1];
      // Data sits at positions 3,5,6,7,9..15. Position 3 is dado[0].
      dado_d = {fixed_d[14:8], fixed_d[6:4], fixed_d[2]};
   end

   assign accept = dado_valid_q && bus.dado_ready;
   assign load   = (state_q == CHECK) && (!dado_valid_q || bus.dado_ready);

   // NOTE: the state registers use non-blocking assignments, so each flop samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         dado_q       <= '0;
         dado_valid_q <= 1'b0;
         sindrome_q   <= '0;
         erro_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.rx_valid && !bus.rx_bit) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
               end
            end
            SHIFT: begin
               if (bus.rx_valid) begin
                  shift_q   <= MSB_FIRST ? {shift_q[13:0], bus.rx_bit}
                                         : {bus.rx_bit, shift_q[14:1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd14) state_q <= STOP;
               end
            end
            STOP: begin
               if (bus.rx_valid) begin
                  if (bus.rx_bit) begin
                     state_q <= CHECK;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
            end
            CHECK: begin
               state_q <= IDLE;
               if (!load) overrun_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase

         // Loading in the same cycle as an accept keeps dado_valid high with no bubble.
         if (load) begin
            dado_q       <= dado_d;
            sindrome_q   <= sindrome_d;
            erro_q       <= (sindrome_d != 4'd0);
            dado_valid_q <= 1'b1;
         end else if (accept) begin
            dado_valid_q <= 1'b0;
         end
      end
   end

   assign bus.dado           = dado_q;
   assign bus.dado_valid     = dado_valid_q;
   assign bus.sindrome       = sindrome_q;
   assign bus.erro_corrigido = erro_q;
   assign bus.frame_err      = frame_err_q;
   assign bus.overrun        = overrun_q;

`ifdef HAMMING_STATS_EN
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] cnt_frame_err;
   logic [CNT_W-1:0] cnt_overrun;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt_q     <= '0;
         cnt_frame_err <= '0;
         cnt_overrun   <= '0;
      end else begin
         if (load && (sindrome_d != 4'd0) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ONE;
         if (frame_err_q && (cnt_frame_err != '1)) cnt_frame_err <= cnt_frame_err + ONE;
         if (overrun_q && (cnt_overrun != '1)) cnt_overrun <= cnt_overrun + ONE;
      end
   end

   assign bus.err_count = err_cnt_q;
`else
   assign bus.err_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_receptor_hamming_serial.sv
// Scoreboard bench for receptor_hamming_serial. One instance is MSB-first and one is LSB-first.
// The stimulus pushes the hand-computed words. A negedge monitor pops and compares each word the DUT hands over.
module tb_receptor_hamming_serial;
   localparam int CNT_W = 8;
`ifdef HAMMING_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [10:0]      dado;
      logic [3:0]       sin;
      logic             erro;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   receptor_hamming_serial_if #(.CNT_W(CNT_W)) bus_m ();
   receptor_hamming_serial_if #(.CNT_W(CNT_W)) bus_l ();

   receptor_hamming_serial #(.CNT_W(CNT_W), .MSB_FIRST(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus_m)
   );
   receptor_hamming_serial #(.CNT_W(CNT_W), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .bus(bus_l)
   );

   exp_t q_m[$];
   exp_t q_l[$];
   exp_t e_m;
   exp_t e_l;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_ovr = 0;
   int   n_fe = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [CNT_W-1:0] cnt_exp(input int n);
      return STATS_EN ? CNT_W'(n) : '0;
   endfunction

   function automatic exp_t mk(input logic [10:0] d, input logic [3:0] s, input logic er, input int c);
      exp_t e;
      e.dado = d;
      e.sin  = s;
      e.erro = er;
      e.cnt  = cnt_exp(c);
      return e;
   endfunction

   // Monitor: a handshake seen at negedge completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_m.overrun) n_ovr++;
         if (bus_m.frame_err) n_fe++;
         if (bus_m.dado_valid && bus_m.dado_ready) begin
            if (q_m.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL msb_unexpected_word: got dado=%0h, none pending", bus_m.dado);
            end else begin
               e_m = q_m.pop_front();
               check("msb_dado", 32'(bus_m.dado), 32'(e_m.dado));
               check("msb_sindrome", 32'(bus_m.sindrome), 32'(e_m.sin));
               check("msb_erro", 32'(bus_m.erro_corrigido), 32'(e_m.erro));
               check("msb_err_count", 32'(bus_m.err_count), 32'(e_m.cnt));
            end
         end
         if (bus_l.dado_valid && bus_l.dado_ready) begin
            if (q_l.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL lsb_unexpected_word: got dado=%0h, none pending", bus_l.dado);
            end else begin
               e_l = q_l.pop_front();
               check("lsb_dado", 32'(bus_l.dado), 32'(e_l.dado));
               check("lsb_sindrome", 32'(bus_l.sindrome), 32'(e_l.sin));
               check("lsb_erro", 32'(bus_l.erro_corrigido), 32'(e_l.erro));
               check("lsb_err_count", 32'(bus_l.err_count), 32'(e_l.cnt));
            end
         end
      end
   end

   task automatic drive_bit(input bit lsb, input logic b);
      @(posedge clk);
      #1;
      if (lsb) begin
         bus_l.rx_valid = 1'b1;
         bus_l.rx_bit   = b;
      end else begin
         bus_m.rx_valid = 1'b1;
         bus_m.rx_bit   = b;
      end
   endtask

   task automatic idle_cycle(input logic garbage);
      @(posedge clk);
      #1;
      bus_m.rx_valid = 1'b0;
      bus_l.rx_valid = 1'b0;
      bus_m.rx_bit   = garbage;
      bus_l.rx_bit   = garbage;
   endtask

   // Sends start, 15 code bits in the order the target instance expects, then the stop bit.
   // It returns #1 after the edge that follows the stop strobe, so the DUT is in CHECK.
   task automatic send_frame(input logic [14:0] cw, input logic stop, input bit lsb);
      drive_bit(lsb, 1'b0);
      for (int i = 0; i < 15; i++) begin
         if (i % 5 == 3) idle_cycle(~cw[i]);
         drive_bit(lsb, lsb ? cw[i] : cw[14-i]);
      end
      drive_bit(lsb, stop);
      idle_cycle(1'b1);
   endtask

   task automatic check_latency(input string name);
      check({name, "_valid_T1"}, 32'(bus_m.dado_valid), 32'd0);
      @(posedge clk);
      #1;
      check({name, "_valid_T2"}, 32'(bus_m.dado_valid), 32'd1);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((q_m.size() != 0 || q_l.size() != 0) && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      check({name, "_drained"}, 32'(q_m.size() + q_l.size()), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ovr0;
      int fe0;
      rst_n            = 1'b0;
      bus_m.rx_valid   = 1'b0;
      bus_m.rx_bit     = 1'b1;
      bus_m.dado_ready = 1'b1;
      bus_l.rx_valid   = 1'b0;
      bus_l.rx_bit     = 1'b1;
      bus_l.dado_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dado", 32'(bus_m.dado), 32'd0);
      check("rst_valid", 32'(bus_m.dado_valid), 32'd0);
      check("rst_err_count", 32'(bus_m.err_count), 32'd0);
      rst_n = 1'b1;
      repeat (2) idle_cycle(1'b1);

      // 1: clean codeword, latency of 2 cycles after the stop strobe
      q_m.push_back(mk(11'h001, 4'd0, 1'b0, 0));
      send_frame(15'h0007, 1'b1, 1'b0);
      check_latency("t1");
      wait_drain("t1");

      // 2: position 5 flipped
      q_m.push_back(mk(11'h001, 4'd5, 1'b1, 1));
      send_frame(15'h0017, 1'b1, 1'b0);
      check_latency("t2");
      wait_drain("t2");
      check("t2_err_count", 32'(bus_m.err_count), 32'(cnt_exp(1)));

      // 3: held word and overrun drop
      bus_m.dado_ready = 1'b0;
      q_m.push_back(mk(11'h7FF, 4'd0, 1'b0, 1));
      send_frame(15'h7FFF, 1'b1, 1'b0);
      check_latency("t3");
      ovr0 = n_ovr;
      send_frame(15'h0000, 1'b1, 1'b0);
      repeat (3) idle_cycle(1'b1);
      check("t3_overrun_pulses", 32'(n_ovr - ovr0), 32'd1);
      check("t3_held_dado", 32'(bus_m.dado), 32'h7FF);
      check("t3_held_valid", 32'(bus_m.dado_valid), 32'd1);
      check("t3_held_sindrome", 32'(bus_m.sindrome), 32'd0);
      check("t3_err_count", 32'(bus_m.err_count), 32'(cnt_exp(1)));
      bus_m.dado_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t3_valid_drop", 32'(bus_m.dado_valid), 32'd0);
      wait_drain("t3");

      // 4: stop bit 0, then a good frame
      fe0 = n_fe;
      send_frame(15'h0007, 1'b0, 1'b0);
      repeat (2) idle_cycle(1'b1);
      check("t4_frame_err_pulses", 32'(n_fe - fe0), 32'd1);
      check("t4_no_valid", 32'(bus_m.dado_valid), 32'd0);
      q_m.push_back(mk(11'h001, 4'd0, 1'b0, 1));
      send_frame(15'h0007, 1'b1, 1'b0);
      check_latency("t4");
      wait_drain("t4");

      // 5: reset after 8 code bits
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b1);
      @(posedge clk);
      #1;
      bus_m.rx_valid = 1'b0;
      rst_n          = 1'b0;
      @(posedge clk);
      #1;
      check("t5_rst_dado", 32'(bus_m.dado), 32'd0);
      check("t5_rst_valid", 32'(bus_m.dado_valid), 32'd0);
      check("t5_rst_sindrome", 32'(bus_m.sindrome), 32'd0);
      check("t5_rst_erro", 32'(bus_m.erro_corrigido), 32'd0);
      check("t5_rst_flags", 32'({bus_m.frame_err, bus_m.overrun}), 32'd0);
      check("t5_rst_err_count", 32'(bus_m.err_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_m.push_back(mk(11'h000, 4'd0, 1'b0, 0));
      send_frame(15'h0000, 1'b1, 1'b0);
      check_latency("t5");
      wait_drain("t5");

      // 6: LSB-first instance
      q_l.push_back(mk(11'h001, 4'd5, 1'b1, 1));
      send_frame(15'h0017, 1'b1, 1'b1);
      check("t6_valid_T1", 32'(bus_l.dado_valid), 32'd0);
      @(posedge clk);
      #1;
      check("t6_valid_T2", 32'(bus_l.dado_valid), 32'd1);
      wait_drain("t6");
      check("t6_err_count", 32'(bus_l.err_count), 32'(cnt_exp(1)));

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
